fuel_level_ctrl: RTL and testbench

Sensor-side front end of the dashboard fuel display. Takes raw 4-bit fuel-sender samples, filters them with a 4-sample moving average and hysteresis, and runs a drive-mode state machine (fuel / battery / empty). Its oFLvl_out and oBMode_out drive the seven-segment fuel gauge's iFLvl_in and iBMode_in directly.

---
 rtl/fuel_level_ctrl_pkg.sv | 22 ++
 rtl/fuel_level_ctrl_if.sv | 26 ++
 rtl/fuel_avg4.sv | 38 +++
 rtl/fuel_level_ctrl.sv | 129 ++++++++++++
 tb/tb_fuel_level_ctrl.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/fuel_level_ctrl_pkg.sv
// Shared types and constants for the fuel-level front end: drive-mode encodings,
// default filter/dwell settings and the endpoint level values.
package fuel_level_ctrl_pkg;

    typedef enum logic [1:0] {
        FUEL  = 2'd0,
        BATT  = 2'd1,
        EMPTY = 2'd2
    } fuel_state_e;

    localparam int HYST_DEF   = 2;
    localparam int DWELL_DEF  = 4;
    localparam int LOW_TH_DEF = 2;

    localparam logic [3:0] LVL_EMPTY = 4'h0;
    localparam logic [3:0] LVL_FULL  = 4'hF;

    function automatic logic [3:0] abs_diff(input logic [3:0] a, input logic [3:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/fuel_level_ctrl_if.sv
// Sender-side bus of the fuel front end: raw samples and mode requests in,
// filtered level and mode flags out to the seven-segment gauge.
//
// Handshake: iSValid_in is a single-cycle strobe with no ready; every strobed
// iSample_in is accepted on that rising edge. Other inputs are level-sensitive.
interface fuel_level_ctrl_if;
    logic [3:0] iSample_in;
    logic       iSValid_in;
    logic       iEVReq_in;
    logic       iBatOk_in;
    logic [3:0] oFLvl_out;
    logic       oBMode_out;
    logic       oLvlValid_out;
    logic       oLowFuel_out;
    logic       oEmpty_out;

    modport slave (
        input  iSample_in, iSValid_in, iEVReq_in, iBatOk_in,
        output oFLvl_out, oBMode_out, oLvlValid_out, oLowFuel_out, oEmpty_out
    );

    modport master (
        output iSample_in, iSValid_in, iEVReq_in, iBatOk_in,
        input  oFLvl_out, oBMode_out, oLvlValid_out, oLowFuel_out, oEmpty_out
    );
endinterface

// File: rtl/fuel_avg4.sv
// Four-sample moving average: shift buffer, running sum and saturating fill count.
module fuel_avg4 (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sample,
    input  logic       strobe,
    output logic [3:0] avg,
    output logic       valid
);

    logic [3:0] samples_q [4];
    logic [5:0] sum_q;
    logic [2:0] fill_q;

    // Running sum adds the new sample and drops the oldest; empty slots hold 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                samples_q[i] <= 4'h0;
            end
            sum_q  <= 6'd0;
            fill_q <= 3'd0;
        end else if (strobe) begin
            samples_q[0] <= sample;
            for (int i = 1; i < 4; i++) begin
                samples_q[i] <= samples_q[i-1];
            end
            sum_q <= sum_q + {2'b00, sample} - {2'b00, samples_q[3]};
            if (fill_q != 3'd4) begin
                fill_q <= fill_q + 3'd1;
            end
        end
    end

    assign avg   = sum_q[5:2];
    assign valid = (fill_q == 3'd4);

endmodule

// File: rtl/fuel_level_ctrl.sv
// Fuel display front end: averaged level with hysteresis, low-fuel flag and the
// fuel/battery/empty drive-mode FSM with a dwell filter on every transition.
module fuel_level_ctrl
    import fuel_level_ctrl_pkg::*;
#(
    parameter int HYST   = HYST_DEF,
    parameter int DWELL  = DWELL_DEF,
    parameter int LOW_TH = LOW_TH_DEF
) (
    input  logic                iClk_in,
    input  logic                iRst_in,
    fuel_level_ctrl_if.slave    bus,
    output fuel_state_e         dbg_state
);

    localparam logic [3:0] HYST4   = 4'(HYST);
    localparam logic [3:0] DWELL4  = 4'(DWELL);
    localparam logic [3:0] LOW_TH4 = 4'(LOW_TH);

    logic [3:0] avg;
    logic       avg_valid;

    fuel_avg4 u_avg (
        .clk    (iClk_in),
        .rst    (iRst_in),
        .sample (bus.iSample_in),
        .strobe (bus.iSValid_in),
        .avg    (avg),
        .valid  (avg_valid)
    );

    logic [3:0] lvl_q;
    logic       loaded_q;
    logic       low_q;
    logic [3:0] diff;

    assign diff = abs_diff(avg, lvl_q);

    // loaded_q marks that the displayed level holds a real average, so the
    // reset value 0 is never mistaken for an empty tank.
    always_ff @(posedge iClk_in) begin
        if (iRst_in) begin
            lvl_q    <= LVL_EMPTY;
            loaded_q <= 1'b0;
            low_q    <= 1'b0;
        end else begin
            low_q <= loaded_q && (lvl_q <= LOW_TH4);
            if (avg_valid) begin
                if (!loaded_q) begin
                    lvl_q    <= avg;
                    loaded_q <= 1'b1;
                end else if (diff >= HYST4 || avg == LVL_EMPTY || avg == LVL_FULL) begin
                    lvl_q <= avg;
                end
            end
        end
    end

    logic        l0;
    fuel_state_e state_q, state_d;
    fuel_state_e tgt_q, tgt_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  run;
    logic        cond;

    assign l0 = loaded_q && (lvl_q == LVL_EMPTY);

    always_ff @(posedge iClk_in) begin
        if (iRst_in) begin
            state_q <= FUEL;
            tgt_q   <= FUEL;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tgt_d   = state_q;
        cnt_d   = 4'd0;
        cond    = 1'b0;
        run     = 4'd0;
        unique case (state_q)
            FUEL: begin
                if (bus.iBatOk_in && (bus.iEVReq_in || l0)) begin
                    cond = 1'b1; tgt_d = BATT;
                end else if (l0 && !bus.iBatOk_in) begin
                    cond = 1'b1; tgt_d = EMPTY;
                end
            end
            BATT: begin
                if (!bus.iBatOk_in && l0) begin
                    cond = 1'b1; tgt_d = EMPTY;
                end else if (!l0 && (!bus.iBatOk_in || !bus.iEVReq_in)) begin
                    cond = 1'b1; tgt_d = FUEL;
                end
            end
            EMPTY: begin
                if (bus.iBatOk_in) begin
                    cond = 1'b1; tgt_d = BATT;
                end else if (!l0) begin
                    cond = 1'b1; tgt_d = FUEL;
                end
            end
            default: state_d = FUEL;
        endcase
        // A run only continues while the same target was pending last cycle.
        if (cond) begin
            run = (tgt_d == tgt_q) ? cnt_q : 4'd0;
            if (run + 4'd1 >= DWELL4) begin
                state_d = tgt_d;
                cnt_d   = 4'd0;
            end else begin
                cnt_d = run + 4'd1;
            end
        end
    end

    assign bus.oFLvl_out     = lvl_q;
    assign bus.oLvlValid_out = avg_valid;
    assign bus.oLowFuel_out  = low_q;
    assign bus.oBMode_out    = (state_q == BATT);
    assign bus.oEmpty_out    = (state_q == EMPTY);
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_fuel_level_ctrl.sv
// Directed bench for fuel_level_ctrl: averaging, hysteresis, dwell-filtered mode
// changes, empty handling, full scale and mid-operation reset.
module tb_fuel_level_ctrl;
    import fuel_level_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    fuel_state_e dbg_state;
    int          errors = 0;
    int          checks = 0;

    fuel_level_ctrl_if bus();

    fuel_level_ctrl #(.HYST(2), .DWELL(4), .LOW_TH(2)) dut (
        .iClk_in   (clk),
        .iRst_in   (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [3:0] s);
        bus.iSample_in = s;
        bus.iSValid_in = 1'b1;
        step(1);
        bus.iSValid_in = 1'b0;
    endtask

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.iSample_in = 4'h0;
        bus.iSValid_in = 1'b0;
        bus.iEVReq_in  = 1'b0;
        bus.iBatOk_in  = 1'b0;
        step(2);
        chk("rst_lvl",   bus.oFLvl_out, 4'h0);
        chk("rst_bmode", {3'b0, bus.oBMode_out}, 4'h0);
        chk("rst_valid", {3'b0, bus.oLvlValid_out}, 4'h0);
        chk("rst_low",   {3'b0, bus.oLowFuel_out}, 4'h0);
        chk("rst_empty", {3'b0, bus.oEmpty_out}, 4'h0);
        chk("rst_state", {2'b0, dbg_state}, {2'b0, FUEL});
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_fill();
        send(4'h4);
        send(4'h8);
        send(4'hC);
        chk("fill_valid_3", {3'b0, bus.oLvlValid_out}, 4'h0);
        send(4'h0);
        chk("fill_valid_4", {3'b0, bus.oLvlValid_out}, 4'h1);
        step(1);
        chk("fill_lvl", bus.oFLvl_out, 4'h6);
        step(1);
        chk("fill_low", {3'b0, bus.oLowFuel_out}, 4'h0);
    endtask

    task automatic test_hysteresis();
        // Four 7s: averages 6,6,5,7, all within HYST of 6.
        for (int i = 0; i < 4; i++) send(4'h7);
        step(1);
        chk("hyst_hold", bus.oFLvl_out, 4'h6);
        // Four 8s: averages 7,7,7,8; the last moves by 2.
        for (int i = 0; i < 4; i++) send(4'h8);
        step(1);
        chk("hyst_move", bus.oFLvl_out, 4'h8);
    endtask

    task automatic test_ev_dwell();
        bus.iBatOk_in = 1'b1;
        bus.iEVReq_in = 1'b1;
        step(3);
        bus.iEVReq_in = 1'b0;
        step(1);
        chk("ev_short_pulse", {3'b0, bus.oBMode_out}, 4'h0);
        bus.iEVReq_in = 1'b1;
        step(3);
        chk("ev_edge3", {3'b0, bus.oBMode_out}, 4'h0);
        step(1);
        chk("ev_edge4", {3'b0, bus.oBMode_out}, 4'h1);
        bus.iEVReq_in = 1'b0;
        step(3);
        chk("ev_drop_edge3", {3'b0, bus.oBMode_out}, 4'h1);
        step(1);
        chk("ev_drop_edge4", {3'b0, bus.oBMode_out}, 4'h0);
        chk("ev_state_fuel", {2'b0, dbg_state}, {2'b0, FUEL});
    endtask

    task automatic test_auto_switch_empty();
        // Zeros from level 8: averages 6,4,2,0, each a step of at least HYST.
        for (int i = 0; i < 4; i++) send(4'h0);
        chk("zero_lvl_2", bus.oFLvl_out, 4'h2);
        step(1);
        chk("zero_snap", bus.oFLvl_out, 4'h0);
        chk("zero_low", {3'b0, bus.oLowFuel_out}, 4'h1);
        step(3);
        chk("auto_edge3", {3'b0, bus.oBMode_out}, 4'h0);
        step(1);
        chk("auto_batt", {3'b0, bus.oBMode_out}, 4'h1);
        bus.iBatOk_in = 1'b0;
        step(3);
        chk("empty_edge3", {3'b0, bus.oEmpty_out}, 4'h0);
        step(1);
        chk("empty_flag", {3'b0, bus.oEmpty_out}, 4'h1);
        chk("empty_bmode", {3'b0, bus.oBMode_out}, 4'h0);
    endtask

    task automatic test_refuel_full_scale();
        // F samples from empty: averages 3,7,B,F; leaves EMPTY once level is nonzero.
        for (int i = 0; i < 4; i++) send(4'hF);
        chk("refuel_lvl_b", bus.oFLvl_out, 4'hB);
        step(1);
        chk("full_lvl", bus.oFLvl_out, 4'hF);
        chk("refuel_still_empty", {3'b0, bus.oEmpty_out}, 4'h1);
        step(1);
        chk("refuel_empty_clear", {3'b0, bus.oEmpty_out}, 4'h0);
        chk("refuel_state", {2'b0, dbg_state}, {2'b0, FUEL});
        chk("full_low", {3'b0, bus.oLowFuel_out}, 4'h0);
    endtask

    task automatic test_back_to_back_reset();
        // Back-to-back 8s from full: averages D,B,9,8; the last is within HYST of 9.
        for (int i = 0; i < 4; i++) send(4'h8);
        step(1);
        chk("b2b_lvl", bus.oFLvl_out, 4'h9);
        bus.iBatOk_in = 1'b1;
        bus.iEVReq_in = 1'b1;
        step(4);
        chk("pre_rst_batt", {3'b0, bus.oBMode_out}, 4'h1);
        rst = 1'b1;
        step(1);
        chk("mid_rst_lvl",   bus.oFLvl_out, 4'h0);
        chk("mid_rst_bmode", {3'b0, bus.oBMode_out}, 4'h0);
        chk("mid_rst_valid", {3'b0, bus.oLvlValid_out}, 4'h0);
        chk("mid_rst_low",   {3'b0, bus.oLowFuel_out}, 4'h0);
        chk("mid_rst_empty", {3'b0, bus.oEmpty_out}, 4'h0);
        chk("mid_rst_state", {2'b0, dbg_state}, {2'b0, FUEL});
        rst = 1'b0;
        bus.iBatOk_in = 1'b0;
        bus.iEVReq_in = 1'b0;
        for (int i = 0; i < 3; i++) send(4'h5);
        chk("refill_valid_3", {3'b0, bus.oLvlValid_out}, 4'h0);
        send(4'h5);
        chk("refill_valid_4", {3'b0, bus.oLvlValid_out}, 4'h1);
        step(1);
        chk("refill_lvl", bus.oFLvl_out, 4'h5);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_hysteresis();
        test_ev_dwell();
        test_auto_switch_empty();
        test_refuel_full_scale();
        test_back_to_back_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
